alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
//  Issue stage directly upstream of the ALU. Accepts 9-bit ALU instructions over a valid/ready handshake,
//  reads operands from an 8x8-bit register file, drives x/y/m/math_op/alu_en/alu_rs for exactly one cycle,
//  then writes the ALU result back: r_out goes to the register file, s_out bit0 goes to the status flag.
//  Multi-cycle and non-pipelined: one instruction in flight, 4 cycles from accept to done.
// PARAMETERS
//  DW      8   datapath width; must match the ALU.
//  NREG    8   register-file depth, index width $clog2(NREG)=3.
//  M_REG   7   register driven onto m (EQL5 mask operand).
// PORTS
//  clk          in   1   single clock, all state on posedge.
//  rst_n        in   1   synchronous, active-low reset.
//  instr        in   9   [8:5] math op (cast to instr_pack::math), [4:2] x/dest reg, [1:0] y reg (r0..r3).
//  instr_valid  in   1   instr is presented.
//  instr_ready  out  1   high only in IDLE; transfer when valid&&ready.
//  ld_en        in   1   external register load (program/test setup).
//  ld_addr      in   3   load target register.
//  ld_data      in   8   load value.
//  ld_drop      out  1   1-cycle pulse: ld_en arrived while not IDLE; load discarded.
//  x, y, m      out  8   ALU operands, registered.
//  math_op      out  4   ALU operation (instr_pack::math), registered.
//  alu_en       out  1   ALU enable, high exactly one cycle per legal instruction.
//  alu_rs       out  1   0: result goes to r_out, 1: result goes to s_out.
//  r_out, s_out in   8   ALU results, sampled in WB.
//  flag         out  1   status bit, s_out[0] of the last s-class instruction.
//  done         out  1   1-cycle pulse when writeback completes.
//  illegal      out  1   1-cycle pulse when an unsupported opcode (ROL) is accepted.
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): all registers and flag set to 0; x/y/m set to 0; math_op set to ADD.
//   alu_en, alu_rs, done, illegal and ld_drop set to 0; FSM set to IDLE. Reset wins over every other input.
//  FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
//   IDLE: instr_ready=1. On valid: latch instr. ROL goes to IDLE with illegal=1 and no alu_en. Any other op goes to READ.
//   READ: x<=reg[instr[4:2]], y<=reg[{1'b0,instr[1:0]}], m<=reg[M_REG], math_op<=op.
//     Sets alu_rs<=1 for EQL8/EQL5/PARx/PARy and alu_rs<=0 for all other ops.
//   EXEC: alu_en=1 for this cycle only; operands stay stable.
//   WB: alu_en=0. If alu_rs==0, reg[instr[4:2]]<=r_out. If alu_rs==1, flag<=s_out[0] and no register is written.
//     done=1 this cycle; the next state is IDLE.
//  Latency: accept at cycle T, alu_en at T+2, register/flag update and done at T+3, instr_ready at T+4.
//  x/y/m/math_op/alu_rs hold their values after WB until the next READ.
//  Load port: written at the posedge in IDLE. If ld_en and an accepted instr occur in the same IDLE cycle, both
//   take effect and the load is visible to that instruction's READ. If ld_en occurs outside IDLE: no write, ld_drop=1.
//  WB write and an external load are never simultaneous (the load is only accepted in IDLE).
//  Arithmetic: none local; 8-bit values pass through, with wrap handled in the ALU. y index is zero-extended.
//  Reset mid-operation: the in-flight instruction is discarded; no writeback and no done pulse.
//  instr_valid held high with ready low: no effect; instr is sampled only when handshaking.
// STRUCTURE
//  instr_pack gains: typedef enum logic[1:0] {IDLE,READ,EXEC,WB} issue_state;
//   a function is_s_class(math) for alu_rs decode; a constant ILLEGAL_OP = ROL. The existing math enum is reused.
//  Sub-module alu_regfile: 8x8 storage, 3 async read ports, 1 sync write port, synchronous active-low reset.
//   The write port is muxed between WB and load by FSM state.
// TESTING
//  1. ld r1=0x05, r2=0x03; instr={ADD,3'd1,2'd2} -> alu_en at T+2, x=0x05, y=0x03, alu_rs=0; done at T+3; r1==0x08.
//  2. r1=0x03, r2=0x05; {SUB,1,2} -> r1==0xFE; flag unchanged.
//  3. r4=0xA5, r3=0xA5; {EQL8,4,3} -> alu_rs=1, flag==1, r4 still 0xA5; then r3=0x00 -> flag==0.
//  4. {ROL,1,1} -> illegal at T+1, alu_en never asserted, registers unchanged, instr_ready=1 next cycle.
//  5. {ADD,1,2} accepted; rst_n=0 during EXEC -> all registers 0, FSM IDLE, no done pulse, alu_en=0 next cycle.
//  6. ld_en in READ -> ld_drop=1, target unchanged; ld_en with accept in IDLE (r2<=0x10) -> result uses 0x10.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// instr_pack: shared types for the ALU issue stage.
//   math        - 4-bit ALU operation encoding (instr[8:5]).
//   issue_instr - packed view of the 9-bit issue word {op, x/dest reg, y reg}.
//   issue_state - issue FSM states.
//   is_s_class  - ops whose result lands in s_out (status) rather than r_out.
package instr_pack;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND8 = 4'd2,
    OR8  = 4'd3,
    XOR8 = 4'd4,
    NOT8 = 4'd5,
    SHL  = 4'd6,
    SHR  = 4'd7,
    ROR  = 4'd8,
    ROL  = 4'd9,
    INC  = 4'd10,
    DEC  = 4'd11,
    EQL8 = 4'd12,
    EQL5 = 4'd13,
    PARx = 4'd14,
    PARy = 4'd15
  } math;

  // ROL is encoded but the ALU behind this stage does not implement it.
  localparam math ILLEGAL_OP = ROL;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} issue_state;

  typedef struct packed {
    math        op;
    logic [2:0] xr;   // x operand and destination register
    logic [1:0] yr;   // y operand, r0..r3 only
  } issue_instr;

  // s-class ops produce a status bit; they never write the register file.
  function automatic logic is_s_class(input math op);
    return op inside {EQL8, EQL5, PARx, PARy};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW register file for the issue stage.
//   clk, rst_n          - clock, synchronous active-low reset (clears all entries)
//   we_i/waddr_i/wdata_i - single synchronous write port
//   raddr_{x,y,m}_i      - three asynchronous read addresses
//   rdata_{x,y,m}_o      - corresponding read data
module alu_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_x_i,
  input  logic [AW-1:0] raddr_y_i,
  input  logic [AW-1:0] raddr_m_i,
  output logic [DW-1:0] rdata_x_o,
  output logic [DW-1:0] rdata_y_o,
  output logic [DW-1:0] rdata_m_o
);

  logic [NREG-1:0][DW-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (!rst_n)    regs_q <= '0;
    else if (we_i) regs_q[waddr_i] <= wdata_i;
  end

  assign rdata_x_o = regs_q[raddr_x_i];
  assign rdata_y_o = regs_q[raddr_y_i];
  assign rdata_m_o = regs_q[raddr_m_i];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: non-pipelined issue stage in front of the ALU.
// One instruction in flight: IDLE(accept) -> READ -> EXEC -> WB -> IDLE.
//   clk, rst_n              - clock, synchronous active-low reset
//   instr/instr_valid/ready - 9-bit instruction handshake, ready only in IDLE
//   ld_en/ld_addr/ld_data   - external register load, honoured only in IDLE
//   ld_drop                 - pulse: a load arrived while busy and was discarded
//   x, y, m, math_op        - registered ALU operands and operation
//   alu_en, alu_rs          - ALU enable (one cycle) and result select (1 = s_out)
//   r_out, s_out            - ALU results, sampled in WB
//   flag                    - s_out[0] of the last s-class instruction
//   done, illegal           - pulses: writeback complete / ROL rejected
module alu_issue
  import instr_pack::*;
#(
  parameter int DW    = 8,
  parameter int NREG  = 8,
  parameter int M_REG = 7,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [8:0]    instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_drop,
  output logic [DW-1:0] x,
  output logic [DW-1:0] y,
  output logic [DW-1:0] m,
  output math           math_op,
  output logic          alu_en,
  output logic          alu_rs,
  input  logic [DW-1:0] r_out,
  input  logic [DW-1:0] s_out,
  output logic          flag,
  output logic          done,
  output logic          illegal
);

  issue_state state_q, state_d;
  issue_instr instr_q, instr_w;

  logic [DW-1:0] x_q, y_q, m_q;
  math           math_op_q;
  logic          alu_en_q, alu_rs_q, flag_q, done_q, illegal_q, ld_drop_q;

  logic          accept;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rd_x, rd_y, rd_m;

  // Only s_out[0] carries status; keep the rest visibly consumed.
  logic unused_s_hi;
  assign unused_s_hi = ^s_out[DW-1:1];

  assign instr_w = issue_instr'(instr);

  alu_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_x_i (AW'(instr_q.xr)),
    .raddr_y_i (AW'(instr_q.yr)),   // y index zero-extended
    .raddr_m_i (AW'(M_REG)),
    .rdata_x_o (rd_x),
    .rdata_y_o (rd_y),
    .rdata_m_o (rd_m)
  );

  // Next state and write-port steering. The write port belongs to the
  // external load in IDLE and to writeback in WB; the two never overlap.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    unique case (state_q)
      IDLE: begin
        rf_we = ld_en;
        if (instr_valid) begin
          accept = 1'b1;
          if (instr_w.op != ILLEGAL_OP) state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        state_d = IDLE;
        if (!alu_rs_q) begin
          rf_we    = 1'b1;
          rf_waddr = AW'(instr_q.xr);
          rf_wdata = r_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      m_q       <= '0;
      math_op_q <= ADD;
      alu_en_q  <= 1'b0;
      alu_rs_q  <= 1'b0;
      flag_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ld_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (accept) instr_q <= instr_w;
      illegal_q <= accept && (instr_w.op == ILLEGAL_OP);
      ld_drop_q <= ld_en && (state_q != IDLE);
      // alu_en and done are one-cycle markers of EXEC and WB respectively.
      alu_en_q  <= (state_q == READ);
      done_q    <= (state_q == EXEC);
      if (state_q == READ) begin
        x_q       <= rd_x;
        y_q       <= rd_y;
        m_q       <= rd_m;
        math_op_q <= instr_q.op;
        alu_rs_q  <= is_s_class(instr_q.op);
      end
      if ((state_q == WB) && alu_rs_q) flag_q <= s_out[0];
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign x           = x_q;
  assign y           = y_q;
  assign m           = m_q;
  assign math_op     = math_op_q;
  assign alu_en      = alu_en_q;
  assign alu_rs      = alu_rs_q;
  assign flag        = flag_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign ld_drop     = ld_drop_q;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue. The bench plays the ALU: it computes
// r_out/s_out from its own register-file model and checks the issue timing,
// operands, writeback and flag against that model.
module tb_alu_issue;
  import instr_pack::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] instr;
  logic       instr_valid, instr_ready;
  logic       ld_en;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_drop;
  logic [7:0] x, y, m;
  math        math_op;
  logic       alu_en, alu_rs;
  logic [7:0] r_out, s_out;
  logic       flag, done, illegal;

  alu_issue #(.DW(8), .NREG(8), .M_REG(7)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_drop(ld_drop), .x(x), .y(y), .m(m),
    .math_op(math_op), .alu_en(alu_en), .alu_rs(alu_rs), .r_out(r_out),
    .s_out(s_out), .flag(flag), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [7:0] mreg [8];
  logic       mflag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mflag = 1'b0;
  endfunction

  // Behavioural ALU: the unused result port gets random junk so that the
  // issue stage is caught if it samples the wrong one.
  function automatic void alu_ref(input math op, input logic [7:0] a, b, mm,
                                  output logic [7:0] r, output logic [7:0] s);
    r = 8'($urandom);
    s = 8'($urandom);
    case (op)
      ADD:  r = a + b;
      SUB:  r = a - b;
      AND8: r = a & b;
      OR8:  r = a | b;
      XOR8: r = a ^ b;
      NOT8: r = ~a;
      SHL:  r = a << 1;
      SHR:  r = a >> 1;
      ROR:  r = {a[0], a[7:1]};
      INC:  r = a + 8'd1;
      DEC:  r = a - 8'd1;
      EQL8: s[0] = (a == b);
      EQL5: s[0] = ((a ^ b) & mm) == 8'h00;
      PARx: s[0] = ^a;
      PARy: s[0] = ^b;
      default: ;
    endcase
  endfunction

  task automatic check_state(input string tag);
    for (int i = 0; i < 8; i++) chk(tag, dut.u_rf.regs_q[i], mreg[i]);
    chk({tag, "_flag"}, flag, mflag);
  endtask

  task automatic do_load(input int a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = 3'(a); ld_data = d;
    tick();
    ld_en = 1'b0;
    mreg[a] = d;
    chk("ld_drop_idle", ld_drop, 1'b0);
  endtask

  // One full instruction. Optional load in the accept cycle (ld) and an
  // optional load attempt while busy (drop_ld) that must be discarded.
  task automatic run_instr(input math op, input int xd, input int ys,
                           input bit ld, input int la, input logic [7:0] ldd,
                           input bit drop_ld);
    logic [7:0] ex, ey, em, er, es;
    bit srs;
    chk("ready_idle", instr_ready, 1'b1);
    instr = {op, 3'(xd), 2'(ys)};
    instr_valid = 1'b1;
    ld_en = ld; ld_addr = 3'(la); ld_data = ldd;
    if (ld) mreg[la] = ldd;
    tick();                                   // T+1
    instr_valid = 1'b0; ld_en = 1'b0;
    chk("ld_drop_accept", ld_drop, 1'b0);
    if (op == ROL) begin
      chk("illegal", illegal, 1'b1);
      chk("alu_en_rol", alu_en, 1'b0);
      chk("ready_rol", instr_ready, 1'b1);
      check_state("rol_regs");
      return;
    end
    chk("illegal_n", illegal, 1'b0);
    chk("ready_busy", instr_ready, 1'b0);
    chk("alu_en_read", alu_en, 1'b0);
    // Garbage on the handshake while busy must be ignored.
    instr = 9'($urandom); instr_valid = 1'b1;
    ex = mreg[xd]; ey = mreg[ys]; em = mreg[7];
    srs = op inside {EQL8, EQL5, PARx, PARy};
    alu_ref(op, ex, ey, em, er, es);
    if (drop_ld) begin
      ld_en = 1'b1; ld_addr = 3'($urandom); ld_data = 8'($urandom);
    end
    tick();                                   // T+2 EXEC
    ld_en = 1'b0;
    chk("ld_drop", ld_drop, drop_ld);
    chk("alu_en_exec", alu_en, 1'b1);
    chk("x", x, ex);
    chk("y", y, ey);
    chk("m", m, em);
    chk("math_op", math_op, op);
    chk("alu_rs", alu_rs, srs);
    chk("done_exec", done, 1'b0);
    r_out = er; s_out = es;
    tick();                                   // T+3 WB
    chk("alu_en_wb", alu_en, 1'b0);
    chk("done_wb", done, 1'b1);
    chk("x_hold_wb", x, ex);
    instr_valid = 1'b0;
    tick();                                   // T+4 IDLE
    if (srs) mflag = es[0];
    else     mreg[xd] = er;
    chk("done_idle", done, 1'b0);
    chk("ready_back", instr_ready, 1'b1);
    chk("alu_en_idle", alu_en, 1'b0);
    chk("x_hold", x, ex);
    chk("rs_hold", alu_rs, srs);
    check_state("wb_regs");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, instr_ready, 1'b1);
    chk({tag, "_alu_en"}, alu_en, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_illegal"}, illegal, 1'b0);
    chk({tag, "_ld_drop"}, ld_drop, 1'b0);
    chk({tag, "_alu_rs"}, alu_rs, 1'b0);
    chk({tag, "_x"}, x, 8'h00);
    chk({tag, "_y"}, y, 8'h00);
    chk({tag, "_m"}, m, 8'h00);
    chk({tag, "_op"}, math_op, ADD);
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    r_out = '0; s_out = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // ADD r1=5 + r2=3
    do_load(1, 8'h05); do_load(2, 8'h03);
    run_instr(ADD, 1, 2, 0, 0, 8'h00, 0);
    chk("t1_r1", dut.u_rf.regs_q[1], 8'h08);

    // SUB wraps; flag untouched
    do_load(1, 8'h03); do_load(2, 8'h05);
    run_instr(SUB, 1, 2, 0, 0, 8'h00, 0);
    chk("t2_r1", dut.u_rf.regs_q[1], 8'hFE);

    // EQL8 sets then clears flag, r4 untouched
    do_load(4, 8'hA5); do_load(3, 8'hA5);
    run_instr(EQL8, 4, 3, 0, 0, 8'h00, 0);
    chk("t3_flag1", flag, 1'b1);
    chk("t3_r4", dut.u_rf.regs_q[4], 8'hA5);
    do_load(3, 8'h00);
    run_instr(EQL8, 4, 3, 0, 0, 8'h00, 0);
    chk("t3_flag0", flag, 1'b0);

    // ROL rejected
    run_instr(ROL, 1, 1, 0, 0, 8'h00, 0);
    tick();
    chk("t4_illegal_clr", illegal, 1'b0);
    chk("t4_alu_en", alu_en, 1'b0);

    // load dropped while busy, then load in the accept cycle is used
    run_instr(ADD, 5, 1, 0, 0, 8'h00, 1);
    do_load(1, 8'h22);
    run_instr(ADD, 1, 2, 1, 2, 8'h10, 0);
    chk("t6_r1", dut.u_rf.regs_q[1], 8'h32);

    // reset during EXEC discards the instruction
    instr = {ADD, 3'd1, 2'd2}; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("t5_alu_en", alu_en, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check_reset_outputs("t5");
    tick();
    chk("t5_no_done", done, 1'b0);
    chk("t5_no_alu_en", alu_en, 1'b0);

    // random mix
    for (int i = 0; i < 8; i++) do_load(i, 8'($urandom));
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 7)), 8'($urandom));
      run_instr(math'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 7)), 8'($urandom),
                ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
